// File: rtl/vt_screen_writer_pkg.sv
// Shared constants, control codes, writer states and the logical-to-physical
// row rotation used by both the cursor and clear address paths.
package vt_screen_writer_pkg;

  localparam logic [6:0] COLS     = 7'd80;
  localparam logic [4:0] ROWS     = 5'd24;
  localparam logic [6:0] LAST_COL = COLS - 7'd1;
  localparam logic [4:0] LAST_ROW = ROWS - 5'd1;

  localparam logic [6:0] BEL = 7'h07;
  localparam logic [6:0] BS  = 7'h08;
  localparam logic [6:0] TAB = 7'h09;
  localparam logic [6:0] LF  = 7'h0A;
  localparam logic [6:0] CR  = 7'h0D;
  localparam logic [6:0] ESC = 7'h1B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ESC,
    ST_ESC_Y_ROW,
    ST_ESC_Y_COL,
    ST_CLEAR
  } state_e;

  // Both operands are already below ROWS, so a single conditional subtract suffices.
  function automatic logic [4:0] phys_row(input logic [4:0] top, input logic [4:0] row);
    logic [5:0] sum;
    sum = {1'b0, top} + {1'b0, row};
    if (sum >= {1'b0, ROWS}) begin
      sum = sum - {1'b0, ROWS};
    end
    return sum[4:0];
  endfunction

endpackage

// File: rtl/vt_screen_writer_addressmap.sv
// Maps (column, physical row) onto the 2K screen RAM; rows 24+ style slots and
// columns 64..79 fold into the otherwise unused upper quarter of each bank.
module vt_screen_writer_addressmap (
  input  logic [6:0]  col_i,
  input  logic [4:0]  row_i,
  output logic [10:0] addr_o
);

  always_comb begin
    if ((row_i[4:3] == 2'b11) || col_i[6]) begin
      addr_o = {row_i[0], 2'b11, row_i[2:1], row_i[4:3], col_i[3:0]};
    end else begin
      addr_o = {row_i[0], row_i[4:1], col_i[5:0]};
    end
  end

endmodule

// File: rtl/vt_screen_writer.sv
// Writer side of the 80x24 screen: decodes a VT52-style byte stream into
// registered screen RAM writes, cursor motion, scrolling and region clears.
module vt_screen_writer
  import vt_screen_writer_pkg::*;
#(
  parameter logic [6:0] FILL_CHAR = 7'h20,
  parameter int         TAB_STEP  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [10:0] mem_addr,
  output logic [6:0]  mem_data,
  output logic        mem_we,
  output logic [6:0]  curX,
  output logic [4:0]  curY,
  output logic [4:0]  topline,
  output logic        bell
);

  state_e      state_q, state_d;
  logic [6:0]  curx_q, curx_d;
  logic [4:0]  cury_q, cury_d;
  logic [4:0]  top_q, top_d;
  logic [6:0]  prow_q, prow_d;
  logic [6:0]  clr_col_q, clr_col_d;
  logic [4:0]  clr_row_q, clr_row_d;
  logic [6:0]  end_col_q, end_col_d;
  logic [4:0]  end_row_q, end_row_d;
  logic        we_q, we_d;
  logic [10:0] addr_q, addr_d;
  logic [6:0]  data_q, data_d;
  logic        bell_q, bell_d;

  // Index 0 addresses the cursor cell, index 1 the clear counter cell.
  logic [6:0]  map_col  [2];
  logic [4:0]  map_row  [2];
  logic [10:0] map_addr [2];

  assign map_col[0] = curx_q;
  assign map_row[0] = phys_row(top_q, cury_q);
  assign map_col[1] = clr_col_q;
  assign map_row[1] = phys_row(top_q, clr_row_q);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_map
      vt_screen_writer_addressmap u_map (
        .col_i  (map_col[gi]),
        .row_i  (map_row[gi]),
        .addr_o (map_addr[gi])
      );
    end
  endgenerate

  logic [31:0] tab_calc;
  logic [6:0]  tab_stop;
  logic [6:0]  coord;

  assign tab_calc = ((32'(curx_q) / TAB_STEP) + 1) * TAB_STEP;
  assign tab_stop = (tab_calc > 32'(LAST_COL)) ? LAST_COL : tab_calc[6:0];
  // Bytes below 0x20 wrap to large values and therefore fail the range checks.
  assign coord    = in_data - 7'h20;

  always_comb begin
    state_d   = state_q;
    curx_d    = curx_q;
    cury_d    = cury_q;
    top_d     = top_q;
    prow_d    = prow_q;
    clr_col_d = clr_col_q;
    clr_row_d = clr_row_q;
    end_col_d = end_col_q;
    end_row_d = end_row_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    bell_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if ((in_data >= 7'h20) && (in_data <= 7'h7E)) begin
            we_d   = 1'b1;
            addr_d = map_addr[0];
            data_d = in_data;
            if (curx_q != LAST_COL) curx_d = curx_q + 7'd1;
          end else begin
            case (in_data)
              BS:  if (curx_q != 7'd0) curx_d = curx_q - 7'd1;
              TAB: curx_d = tab_stop;
              CR:  curx_d = 7'd0;
              BEL: bell_d = 1'b1;
              ESC: state_d = ST_ESC;
              LF: begin
                if (cury_q < LAST_ROW) begin
                  cury_d = cury_q + 5'd1;
                end else begin
                  // Rotate first; the clear then targets the new bottom row.
                  top_d     = (top_q == LAST_ROW) ? 5'd0 : top_q + 5'd1;
                  state_d   = ST_CLEAR;
                  clr_col_d = 7'd0;
                  clr_row_d = LAST_ROW;
                  end_col_d = LAST_COL;
                  end_row_d = LAST_ROW;
                end
              end
              default: ;
            endcase
          end
        end
      end

      ST_ESC: begin
        if (in_valid) begin
          state_d = ST_IDLE;
          case (in_data)
            7'h41: if (cury_q != 5'd0) cury_d = cury_q - 5'd1;
            7'h42: if (cury_q != LAST_ROW) cury_d = cury_q + 5'd1;
            7'h43: if (curx_q != LAST_COL) curx_d = curx_q + 7'd1;
            7'h44: if (curx_q != 7'd0) curx_d = curx_q - 7'd1;
            7'h48: begin
              curx_d = 7'd0;
              cury_d = 5'd0;
            end
            7'h4A, 7'h4B: begin
              state_d   = ST_CLEAR;
              clr_col_d = curx_q;
              clr_row_d = cury_q;
              end_col_d = LAST_COL;
              end_row_d = (in_data == 7'h4A) ? LAST_ROW : cury_q;
            end
            7'h59: state_d = ST_ESC_Y_ROW;
            default: ;
          endcase
        end
      end

      ST_ESC_Y_ROW: begin
        if (in_valid) begin
          prow_d  = coord;
          state_d = ST_ESC_Y_COL;
        end
      end

      ST_ESC_Y_COL: begin
        if (in_valid) begin
          if (prow_q < 7'(ROWS)) cury_d = prow_q[4:0];
          if (coord < COLS) curx_d = coord;
          state_d = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        we_d   = 1'b1;
        addr_d = map_addr[1];
        data_d = FILL_CHAR;
        if ((clr_col_q == end_col_q) && (clr_row_q == end_row_q)) begin
          state_d = ST_IDLE;
        end else if (clr_col_q == LAST_COL) begin
          clr_col_d = 7'd0;
          clr_row_d = clr_row_q + 5'd1;
        end else begin
          clr_col_d = clr_col_q + 7'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      curx_q    <= 7'd0;
      cury_q    <= 5'd0;
      top_q     <= 5'd0;
      prow_q    <= 7'd0;
      clr_col_q <= 7'd0;
      clr_row_q <= 5'd0;
      end_col_q <= LAST_COL;
      end_row_q <= LAST_ROW;
      we_q      <= 1'b0;
      addr_q    <= 11'd0;
      data_q    <= 7'd0;
      bell_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      curx_q    <= curx_d;
      cury_q    <= cury_d;
      top_q     <= top_d;
      prow_q    <= prow_d;
      clr_col_q <= clr_col_d;
      clr_row_q <= clr_row_d;
      end_col_q <= end_col_d;
      end_row_q <= end_row_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      bell_q    <= bell_d;
    end
  end

  assign in_ready = (state_q != ST_CLEAR);
  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign curX     = curx_q;
  assign curY     = cury_q;
  assign topline  = top_q;
  assign bell     = bell_q;

endmodule

// File: tb/tb_vt_screen_writer.sv
// Scoreboard bench: a terminal model queues expected RAM writes and bell
// pulses; a negedge monitor pops and compares whatever the writer emits.
module tb_vt_screen_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  in_data = 7'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] mem_addr;
  logic [6:0]  mem_data;
  logic        mem_we;
  logic [6:0]  curX;
  logic [4:0]  curY;
  logic [4:0]  topline;
  logic        bell;

  vt_screen_writer dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_we   (mem_we),
    .curX     (curX),
    .curY     (curY),
    .topline  (topline),
    .bell     (bell)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_bell;
    logic [10:0] addr;
    logic [6:0]  data;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec  = 0;
  int  n_fail = 0;
  logic [10:0] last_addr = '0;
  logic [6:0]  last_data = '0;

  // Terminal model: cursor, scroll origin and escape progress as plain integers.
  int m_x, m_y, m_top, m_phase, m_prow;

  function automatic logic [10:0] ref_addr(int col, int row);
    logic [6:0] c;
    logic [4:0] p;
    c = 7'(col);
    p = 5'((m_top + row) % 24);
    if (p[4:3] == 2'b11 || c[6]) return {p[0], 2'b11, p[2:1], p[4:3], c[3:0]};
    return {p[0], p[4:1], c[5:0]};
  endfunction

  function automatic void push_clear(int c0, int r0, int c1, int r1);
    for (int i = r0 * 80 + c0; i <= r1 * 80 + c1; i++) begin
      exp_q.push_back('{1'b0, ref_addr(i % 80, i / 80), 7'h20});
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_x = 0; m_y = 0; m_top = 0; m_phase = 0; m_prow = 0;
  endfunction

  function automatic void model_accept(int b);
    int col;
    case (m_phase)
      0: begin
        if (b >= 32 && b <= 126) begin
          exp_q.push_back('{1'b0, ref_addr(m_x, m_y), 7'(b)});
          m_x = (m_x < 79) ? m_x + 1 : 79;
        end else if (b == 8)  m_x = (m_x > 0) ? m_x - 1 : 0;
        else if (b == 9)      m_x = ((m_x / 8 + 1) * 8 > 79) ? 79 : (m_x / 8 + 1) * 8;
        else if (b == 13)     m_x = 0;
        else if (b == 7)      exp_q.push_back('{1'b1, 11'd0, 7'd0});
        else if (b == 27)     m_phase = 1;
        else if (b == 10) begin
          if (m_y < 23) m_y++;
          else begin
            m_top = (m_top + 1) % 24;
            push_clear(0, 23, 79, 23);
          end
        end
      end
      1: begin
        m_phase = 0;
        case (b)
          65: m_y = (m_y > 0) ? m_y - 1 : 0;
          66: m_y = (m_y < 23) ? m_y + 1 : 23;
          67: m_x = (m_x < 79) ? m_x + 1 : 79;
          68: m_x = (m_x > 0) ? m_x - 1 : 0;
          72: begin m_x = 0; m_y = 0; end
          74: push_clear(m_x, m_y, 79, 23);
          75: push_clear(m_x, m_y, 79, m_y);
          89: m_phase = 2;
          default: ;
        endcase
      end
      2: begin
        m_prow  = b - 32;
        m_phase = 3;
      end
      default: begin
        col = b - 32;
        if (m_prow >= 0 && m_prow < 24) m_y = m_prow;
        if (col >= 0 && col < 80) m_x = col;
        m_phase = 0;
      end
    endcase
  endfunction

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge clock) begin
    ev_t e;
    if (!reset && (mem_we || bell)) begin
      if (mem_we) begin
        last_addr = mem_addr;
        last_data = mem_data;
      end
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: we=%0b bell=%0b addr=0x%0h data=0x%0h, expected nothing",
                 mem_we, bell, mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        if (e.is_bell) begin
          if (!bell || mem_we) begin
            n_fail++;
            $display("FAIL bell_event: got we=%0b bell=%0b, expected bell pulse only", mem_we, bell);
          end else $display("bell pulse");
        end else if (bell || mem_addr != e.addr || mem_data != e.data) begin
          n_fail++;
          $display("FAIL mem_write: got bell=%0b addr=0x%0h data=0x%0h, expected addr=0x%0h data=0x%0h",
                   bell, mem_addr, mem_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic reset_checks(string tag);
    check({tag, "_curX"}, curX, 0);
    check({tag, "_curY"}, curY, 0);
    check({tag, "_topline"}, topline, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_bell"}, bell, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  // Called at a negedge: releases reset and counts busy cycles of the power-up clear.
  task automatic release_and_clear(string tag);
    int cnt = 0;
    model_reset();
    push_clear(0, 0, 79, 23);
    in_data  = 7'h00;
    in_valid = 1'b1;
    reset    = 1'b0;
    while (!in_ready && cnt < 5000) begin
      cnt++;
      @(negedge clock);
    end
    in_valid = 1'b0;
    check({tag, "_busy_cycles"}, cnt, 1920);
    $display("%s: clear done after %0d busy cycles", tag, cnt);
  endtask

  task automatic send(int b);
    int guard = 0;
    while (!in_ready && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    model_accept(b);
    in_data  = 7'(b);
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    check("curX", curX, m_x);
    check("curY", curY, m_y);
    check("topline", topline, m_top);
    $display("byte 0x%02h -> cur=(%0d,%0d) top=%0d", b, curX, curY, topline);
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (!in_ready && cnt < 5000) begin
      cnt++;
      @(negedge clock);
    end
    #1;
  endtask

  initial begin
    int cnt, r, b;
    #12;
    reset_checks("reset");
    @(negedge clock);
    release_and_clear("powerup");

    send(8'h41); send(8'h42); send(13); send(10); send(8'h43);
    check("t2_last_addr", last_addr, 11'h400);
    check("t2_last_data", last_data, 7'h43);
    check("t2_curX", curX, 1);
    check("t2_curY", curY, 1);

    send(27); send(8'h59); send(8'h20); send(8'h6F);
    send(8'h58);
    check("t4_addr_X", last_addr, 11'h30F);
    send(8'h59);
    check("t4_addr_Y", last_addr, 11'h30F);
    check("t4_data_Y", last_data, 7'h59);
    check("t4_curX", curX, 79);

    send(27); send(8'h43);
    check("t5_right_sat", curX, 79);
    send(13); send(27); send(8'h44);
    check("t5_left_sat", curX, 0);
    send(27); send(8'h59); send(8'h23); send(8'h6B);
    send(9);
    check("t5_tab", curX, 79);
    send(27); send(8'h59); send(8'h50); send(8'h25);
    check("t5_bad_row", curY, 3);
    check("t5_col", curX, 5);

    send(27); send(8'h59); send(8'h37); send(8'h20);
    send(10);
    wait_idle(cnt);
    check("t3_scroll_busy", cnt, 80);
    check("t3_topline", topline, 1);
    check("t3_curY", curY, 23);
    check("t3_last_addr", last_addr, 11'h30F);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 50) send($urandom_range(32, 126));
      else if (r < 60) send(13);
      else if (r < 68) send(10);
      else if (r < 72) send(8);
      else if (r < 76) send(9);
      else if (r < 78) send(7);
      else if (r < 90) begin
        b = $urandom_range(0, 8);
        send(27);
        case (b)
          0: send(8'h41); 1: send(8'h42); 2: send(8'h43); 3: send(8'h44);
          4: send(8'h48); 5: send(8'h4A); 6: send(8'h4B); 7: send(8'h5A);
          default: begin
            send(8'h59);
            send($urandom_range(8'h18, 8'h3F));
            send($urandom_range(8'h18, 8'h77));
          end
        endcase
      end else send($urandom_range(0, 127));
    end

    send(27); send(8'h59); send(8'h2A); send(8'h25);
    send(27); send(8'h4A);
    repeat (50) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    reset_checks("midclear_reset");
    exp_q.delete();
    @(negedge clock);
    release_and_clear("reclear");

    for (int i = 0; i < 40; i++) send($urandom_range(0, 127));
    wait_idle(cnt);
    repeat (3) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vt_screen_writer.md
Name: vt_screen_writer

Overview:
Writer side of the 80x24 screen memory that the video generator scans out. Consumes a 7-bit VT52-style character stream over a valid/ready handshake and writes character codes into screen memory. Maintains the cursor position and scroll origin (curX, curY, topline) that the video generator uses for cursor blink and row rotation. Implements printable output, control characters, VT52 escape sequences, and hardware scrolling with line clear.

Parameters:
FILL_CHAR, 7'h20, code written by all clear operations.
TAB_STEP, 8, tab stop spacing in columns.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_data  in  7  received character code
in_valid  in  1  in_data is valid
in_ready  out  1  byte accepted on a cycle where in_valid && in_ready
mem_addr  out  11  screen memory write address, VT52 mapping
mem_data  out  7  screen memory write data
mem_we  out  1  write strobe, one write per cycle
curX  out  7  cursor column, 0..79
curY  out  5  cursor logical row, 0..23
topline  out  5  physical row shown as logical row 0, 0..23
bell  out  1  one-cycle pulse on BEL (0x07)

Behaviour:
- Reset is asynchronous. It forces curX=0, curY=0, topline=0, mem_we=0, bell=0 and state=CLEAR over the full screen, so in_ready=0.
- After reset release, the power-up clear writes FILL_CHAR to all 1920 cells, one per cycle. in_ready goes high on the cycle after the last write.
- If reset asserts mid-operation, any clear in progress or partial escape sequence is abandoned. Memory contents are not guaranteed; power-up clear restarts.
- Address rule: phys_row = topline + row, minus 24 if the sum is >= 24. mem_addr = addressmap(col, phys_row):
  - if (phys_row[4:3]==2'b11) or col[6]: {phys_row[0], 2'b11, phys_row[2:1], phys_row[4:3], col[3:0]}
  - otherwise: {phys_row[0], phys_row[4:1], col[5:0]}
- All memory outputs are registered. A byte accepted in cycle N produces mem_we=1 in cycle N+1, and cursor outputs update in N+1.
- States:
  - IDLE. Accepts bytes.
    - 0x20..0x7E: write the code at (curX, curY), then curX++ saturating at 79. No autowrap; the last column is overwritten.
    - 0x08 BS: curX-- saturating at 0.
    - 0x09 TAB: curX = min(79, next multiple of TAB_STEP greater than curX).
    - 0x0A LF: curY++ if curY < 23. Otherwise scroll:
      - topline = (topline==23) ? 0 : topline+1;
      - enter CLEAR for logical row 23, cols 0..79, using the updated topline;
      - curX and curY are unchanged.
    - 0x0D CR: curX = 0.
    - 0x07 BEL: bell pulse.
    - 0x1B: go to ESC.
    - All other codes, including 0x7F: ignored.
  - ESC. Next byte:
    - 'A': curY-- saturating at 0.
    - 'B': curY++ saturating at 23, no scroll.
    - 'C': curX++ saturating at 79.
    - 'D': curX-- saturating at 0.
    - 'H': home to (0,0).
    - 'J': CLEAR from (curX, curY) to (79,23).
    - 'K': CLEAR from (curX, curY) to (79, curY).
    - 'Y': go to ESC_Y_ROW.
    - Any other byte: ignored, return to IDLE.
  - ESC_Y_ROW: latch byte-0x20 as the pending row, go to ESC_Y_COL.
  - ESC_Y_COL: column = byte-0x20. Apply row if < 24 and column if < 80; an out-of-range coordinate (including byte < 0x20) is left unchanged. Return to IDLE.
- CLEAR:
  - A cell counter (col, row) writes FILL_CHAR each cycle. Column wraps 79->0 with row++.
  - Ends after the write of the end cell, then returns to IDLE.
  - in_ready=0 throughout. Cursor is not moved.
- in_ready = (state != CLEAR). No byte is ever dropped while in_ready=1.
- bell and mem_we are 0 on every cycle not explicitly producing them.

Decomposition:
- Shared package holds:
  - constants COLS=80, ROWS=24;
  - control codes BS, TAB, LF, CR, BEL, ESC;
  - the state enum IDLE, ESC, ESC_Y_ROW, ESC_Y_COL, CLEAR.
- Instantiate the codebase's existing addressmap module twice: once for cursor writes, once for the clear counter, with the output selected by state.
- The phys_row modulo adder is a small shared function in the package.

Test Plan:
1. Reset, then hold in_valid. Required: in_ready=0 for exactly 1920 cycles of mem_we with data 0x20; the first address is 0x000 (0,0) and the address for (64,0) is 0x300. Then in_ready=1.
2. Send 'A','B', then CR LF 'C'. Required: writes 0x41@0x000, 0x42@0x001, 0x43@0x400. Final curX=1, curY=1.
3. Send ESC Y 0x37 0x20, then LF. Required: topline=1; 80 writes of 0x20 to physical row 0 (0x000..0x03F, then 0x300..0x30F); in_ready=0 for those 80 cycles; curY=23.
4. Send ESC Y 0x20 0x6F (col 79), then 'X','Y'. Required: both write at col 79, mapped address 0x30F; curX stays 79.
5. Send ESC 'C' with curX=79, ESC 'D' with curX=0, TAB from col 75, and ESC Y 0x50 0x25. Required:
   - curX stays 79, then stays 0;
   - TAB gives curX=79;
   - row unchanged, col=5.
6. Assert reset during an ESC J clear. Required: all outputs at reset values immediately (asynchronous), then a full 1920-cycle clear after release.
